spec_frame_rx: RTL and testbench
================================

# spec_frame_rx

Receive side of the per-bin spectrum stream protocol (32-bit bin word, 6-bit bin index, valid, fin on the last bin). Captures one 64-bin frame at a time from a spectrum producer such as the pitch-raise stage into a ping-pong buffer and checks bin ordering. Drops malformed or overflowing frames. Replays complete frames in natural bin order to a downstream consumer (IFFT) over a valid/ready handshake.

## Interface
- DW, 32, bin word width ({re[15:0], im[15:0]}, passed through untouched)
- NBINS, 64, bins per frame; must be a power of two
- AW, 6, bin index width, log2(NBINS)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- in_data  in  DW  bin word
- in_valid  in  1  bin word present this cycle; no backpressure on input
- in_freq  in  AW  bin index of in_data
- in_fin  in  1  marks last bin of frame
- out_data  out  DW  replayed bin word
- out_freq  out  AW  replayed bin index
- out_valid  out  1  out_* hold a valid bin
- out_fin  out  1  high with bin NBINS-1
- out_ready  in  1  consumer accepts when out_valid & out_ready
- seq_err  out  1  sticky: ordering or fin error seen
- ovf  out  1  sticky: frame dropped, both banks full
- err_clr  in  1  one-cycle pulse clears seq_err and ovf
- frame_cnt  out  16  frames committed (see Configuration)
- drop_cnt  out  16  frames dropped (see Configuration)

## Operation
- Storage: two banks of NBINS x DW (bank 0/1), full flag per bank. Write pointer wb, read pointer rb, both reset to 0.
- Write FSM states W_IDLE, W_FILL, W_DROP; exp = expected index.
- W_IDLE: on in_valid & in_freq==0: if bank wb is full -> W_DROP, set ovf, drop_cnt++; else write mem[wb][0], exp=1 -> W_FILL. in_valid with nonzero in_freq: ignored, seq_err set.
- W_FILL on in_valid:
  - in_freq==exp: write mem[wb][exp]; exp++.
  - If in_freq==NBINS-1 and in_fin: full[wb]=1, wb^=1, frame_cnt++ -> W_IDLE.
  - in_freq==NBINS-1 without in_fin, or in_fin on any other index: seq_err, drop_cnt++ -> W_IDLE.
  - in_freq==0 (restart): seq_err, drop_cnt++, partial discarded, this word starts a new frame in the same bank (exp=1).
  - Any other index: seq_err, drop_cnt++ -> W_DROP.
- W_DROP: discard words; in_valid & in_freq==0 re-evaluated exactly as in W_IDLE the same cycle; in_fin alone -> W_IDLE.
- Read FSM R_IDLE, R_STREAM. R_IDLE: when full[rb] -> R_STREAM, ra=0. R_STREAM: output register loads mem[rb][ra] when !out_valid or accepted; after bin NBINS-1 accepted: full[rb]=0, rb^=1 -> R_IDLE.
- out_valid drops for no more than one cycle between frames when next bank already full.
- Same-cycle commit into one bank and release of the other: both take effect; no frame lost.
- err_clr together with a new error event: error wins (flag stays 1).
- Counters saturate at 16'hFFFF.

## Timing
- Reset (async assert, sync-released use): out_valid=0, out_fin=0, out_data=0, out_freq=0, seq_err=0, ovf=0, frame_cnt=0, drop_cnt=0, both banks empty, W_IDLE/R_IDLE.
- Latency: fin word committed at edge N; out_valid=1 with bin 0 at edge N+2.
- Output held stable while out_valid & !out_ready.
- Throughput: one bin/cycle when out_ready held high.
- Sticky flags and counters update on the edge after the causing input.

## Configuration
- SPEC_RX_STATUS_EN defined: frame_cnt and drop_cnt implemented as described.
- Not defined: counters not built, frame_cnt and drop_cnt tied to 16'h0; seq_err/ovf and all datapath behaviour unchanged.

## Structure
- Shared package spec_pkg: DW, NBINS, AW defaults; packed bin type {re, im}; write/read state enums.
- One sub-module spec_pp_bank: two-bank storage with full flags, write port (bank, addr, data, commit) and read port (bank, addr, release). spec_frame_rx holds both FSMs, output register, flags, counters.

## Test plan
- Clean frame: bins 0..63 with data 32'h0001_0000+i, fin on 63, out_ready=1 -> out bins 0..63 same data, out_fin on 63, first out_valid 2 cycles after fin, frame_cnt=1.
- Backpressure: out_ready toggled 1/0 each cycle -> all 64 bins delivered once each in order, out_data stable when stalled.
- Overflow: 3 back-to-back frames, out_ready=0 -> frames 1,2 stored, frame 3 dropped, ovf=1, drop_cnt=1; releasing out_ready yields frames 1 then 2.
- Skip: indices 0..9 then 11 -> seq_err=1, drop_cnt=1, no output; following clean frame delivered intact.
- Restart: 0..20 then 0..63 fin -> seq_err=1, exactly one frame output with second frame data.
- Reset mid-stream at bin 30 of output -> out_valid=0 immediately, flags/counters 0, next clean frame delivered from bin 0.

Source files
------------

// File: rtl/spec_pkg.sv
// rtl/spec_pkg.sv - shared sizes, bin type and FSM state encodings for the spectrum frame receiver
package spec_pkg;

    localparam int DW    = 32;
    localparam int NBINS = 64;
    localparam int AW    = 6;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } bin_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DROP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_STREAM
    } rstate_t;

    // Saturating 16-bit increment used by the status counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/spec_pp_bank.sv
// rtl/spec_pp_bank.sv - two-bank ping-pong frame storage with per-bank full flags
module spec_pp_bank
    import spec_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          rel_en,
    output logic [1:0]    full
);

    logic [DW-1:0] mem [2*NBINS];
    logic [1:0]    full_nxt;

    // Bin storage write port; the bank index is the address MSB.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

    // Commit and release may hit different banks on the same edge; both apply.
    always_comb begin
        full_nxt = full;
        if (rel_en) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (commit) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Full flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

endmodule

// File: rtl/spec_frame_rx.sv
// rtl/spec_frame_rx.sv - spectrum frame receiver: ordering check, ping-pong capture, in-order replay (status counters under SPEC_RX_STATUS_EN)
module spec_frame_rx
    import spec_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic [AW-1:0] in_freq,
    input  logic          in_fin,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_freq,
    output logic          out_valid,
    output logic          out_fin,
    input  logic          out_ready,
    output logic          seq_err,
    output logic          ovf,
    input  logic          err_clr,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   drop_cnt
);

    localparam logic [AW-1:0] LAST = AW'(NBINS - 1);

    wstate_t       w_state, w_next;
    rstate_t       r_state, r_next;
    logic [AW-1:0] exp_q, exp_nxt;
    logic          wb, rb;
    logic [AW:0]   ra;
    logic [1:0]    full;
    logic [DW-1:0] rd_data;

    logic wr_en, commit, set_seq, set_ovf, inc_frame, inc_drop;
    logic rd_load, rel_en, ra_clr, accept, start;

    assign start  = in_valid && (in_freq == '0);
    assign accept = out_valid && out_ready;

    spec_pp_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_bank (wb),
        .wr_addr (in_freq),
        .wr_data (in_data),
        .commit  (commit),
        .rd_bank (rb),
        .rd_addr (ra[AW-1:0]),
        .rd_data (rd_data),
        .rel_en  (rel_en),
        .full    (full)
    );

    // Write FSM state, expected index and write bank pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            exp_q   <= '0;
            wb      <= 1'b0;
        end else begin
            w_state <= w_next;
            exp_q   <= exp_nxt;
            wb      <= wb ^ commit;
        end
    end

    // Write FSM: accept in-order bins, commit on fin at the last bin, drop anything malformed.
    always_comb begin
        w_next    = w_state;
        exp_nxt   = exp_q;
        wr_en     = 1'b0;
        commit    = 1'b0;
        set_seq   = 1'b0;
        set_ovf   = 1'b0;
        inc_frame = 1'b0;
        inc_drop  = 1'b0;
        case (w_state)
            W_IDLE, W_DROP: begin
                if (start) begin
                    if (full[wb]) begin
                        w_next   = W_DROP;
                        set_ovf  = 1'b1;
                        inc_drop = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        exp_nxt = AW'(1);
                        w_next  = W_FILL;
                    end
                end else if (in_valid) begin
                    if (w_state == W_IDLE) begin
                        set_seq = 1'b1;
                    end else if (in_fin) begin
                        w_next = W_IDLE;
                    end
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    if (start) begin
                        // Restart: discard the partial frame and reuse the same bank.
                        set_seq  = 1'b1;
                        inc_drop = 1'b1;
                        wr_en    = 1'b1;
                        exp_nxt  = AW'(1);
                    end else if (in_freq == exp_q && in_freq == LAST && in_fin) begin
                        wr_en     = 1'b1;
                        commit    = 1'b1;
                        inc_frame = 1'b1;
                        w_next    = W_IDLE;
                    end else if (in_freq == exp_q && in_freq != LAST && !in_fin) begin
                        wr_en   = 1'b1;
                        exp_nxt = exp_q + AW'(1);
                    end else begin
                        // A frame-ending word returns to idle; a skip waits for the frame end.
                        set_seq  = 1'b1;
                        inc_drop = 1'b1;
                        w_next   = (in_fin || in_freq == LAST) ? W_IDLE : W_DROP;
                    end
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM: stream a full bank; on release go straight to the other bank if it is ready.
    always_comb begin
        r_next  = r_state;
        rd_load = 1'b0;
        rel_en  = 1'b0;
        ra_clr  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (full[rb]) begin
                    r_next = R_STREAM;
                    ra_clr = 1'b1;
                end
            end
            R_STREAM: begin
                rd_load = !ra[AW] && (!out_valid || out_ready);
                if (accept && out_fin) begin
                    rel_en = 1'b1;
                    ra_clr = 1'b1;
                    r_next = full[~rb] ? R_STREAM : R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read pointer, read address and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb        <= 1'b0;
            ra        <= '0;
            out_data  <= '0;
            out_freq  <= '0;
            out_valid <= 1'b0;
            out_fin   <= 1'b0;
        end else begin
            if (rel_en) begin
                rb <= ~rb;
            end
            if (ra_clr) begin
                ra <= '0;
            end else if (rd_load) begin
                ra <= ra + (AW+1)'(1);
            end
            if (rd_load) begin
                out_data  <= rd_data;
                out_freq  <= ra[AW-1:0];
                out_fin   <= (ra[AW-1:0] == LAST);
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_fin   <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            seq_err <= set_seq | (seq_err & ~err_clr);
            ovf     <= set_ovf | (ovf & ~err_clr);
        end
    end

`ifdef SPEC_RX_STATUS_EN
    logic [15:0] frame_q, drop_q;

    // Saturating committed/dropped frame counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            if (inc_frame) begin
                frame_q <= sat_inc(frame_q);
            end
            if (inc_drop) begin
                drop_q <= sat_inc(drop_q);
            end
        end
    end

    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
`else
    logic unused_cnt;
    assign unused_cnt = inc_frame ^ inc_drop;
    assign frame_cnt  = 16'h0;
    assign drop_cnt   = 16'h0;
`endif

endmodule

// File: tb/tb_spec_frame_rx.sv
// tb/tb_spec_frame_rx.sv - directed self-checking bench for spec_frame_rx
module tb_spec_frame_rx;

`ifdef SPEC_RX_STATUS_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic [5:0]  in_freq;
    logic        in_fin;
    logic [31:0] out_data;
    logic [5:0]  out_freq;
    logic        out_valid;
    logic        out_fin;
    logic        out_ready;
    logic        seq_err;
    logic        ovf;
    logic        err_clr;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    spec_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_freq   (in_freq),
        .in_fin    (in_fin),
        .out_data  (out_data),
        .out_freq  (out_freq),
        .out_valid (out_valid),
        .out_fin   (out_fin),
        .out_ready (out_ready),
        .seq_err   (seq_err),
        .ovf       (ovf),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          beat_cnt   = 0;
    int          stall_bad  = 0;
    int          stall_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [5:0]  prev_freq  = '0;
    logic [31:0] got_data [0:1023];
    logic [5:0]  got_freq [0:1023];
    logic        got_fin  [0:1023];

    // Record every accepted beat and watch that stalled outputs hold still.
    always @(negedge clk) begin
        if (prev_stall && out_valid) begin
            stall_seen++;
            if (out_data !== prev_data || out_freq !== prev_freq) stall_bad++;
        end
        if (out_valid && out_ready && beat_cnt < 1024) begin
            got_data[beat_cnt] = out_data;
            got_freq[beat_cnt] = out_freq;
            got_fin[beat_cnt]  = out_fin;
            beat_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_freq  = out_freq;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] f, input logic [31:0] d, input logic fin);
        in_valid = 1'b1;
        in_freq  = f;
        in_data  = d;
        in_fin   = fin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_fin   = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] pat);
        for (int i = 0; i < 64; i++) send(6'(i), pat + 32'(i), i == 63);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beat_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beat_timeout", 64'(beat_cnt >= target), 64'd1);
    endtask

    task automatic verify_frame(input int base, input logic [31:0] pat);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] fi = 6'(i);
            check("bin", {25'd0, got_fin[base+i], got_freq[base+i], got_data[base+i]},
                         {25'd0, (i == 63), fi, pat + 32'(i)});
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    int base;
    int s0;

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_freq = '0; in_fin = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_fin",   64'(out_fin),   64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_freq",  64'(out_freq),  64'd0);
        check("rst_seq_err",   64'(seq_err),   64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame with exact commit-to-output latency.
        out_ready = 1'b1;
        base = beat_cnt;
        send_frame(32'h0001_0000);
        check("lat_n_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_n1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_n2_valid", 64'(out_valid), 64'd1);
        check("lat_n2_freq",  64'(out_freq),  64'd0);
        check("lat_n2_data",  64'(out_data),  64'h0001_0000);
        wait_beats(base + 64, 200);
        verify_frame(base, 32'h0001_0000);
        check("clean_frame_cnt", 64'(frame_cnt), 64'(STAT));
        check("clean_seq_err",   64'(seq_err),   64'd0);
        check("clean_ovf",       64'(ovf),       64'd0);

        // Backpressure: ready toggling every cycle.
        out_ready = 1'b0;
        base = beat_cnt;
        s0 = stall_seen;
        send_frame(32'hB000_0000);
        for (int n = 0; n < 400 && beat_cnt < base + 64; n++) begin
            out_ready = ~out_ready;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        check("bp_count", 64'(beat_cnt - base), 64'd64);
        verify_frame(base, 32'hB000_0000);
        check("bp_stall_stable", 64'(stall_bad), 64'd0);
        check("bp_stall_seen",   64'(stall_seen > s0), 64'd1);
        check("bp_frame_cnt",    64'(frame_cnt), 64'(2 * STAT));

        // Overflow: three frames with the consumer stalled.
        base = beat_cnt;
        for (int k = 1; k <= 3; k++) send_frame(32'hC000_0000 + 32'(k) * 32'h100);
        repeat (4) @(posedge clk);
        #1;
        check("ovf_no_beats",  64'(beat_cnt - base), 64'd0);
        check("ovf_flag",      64'(ovf),       64'd1);
        check("ovf_seq_err",   64'(seq_err),   64'd0);
        check("ovf_drop_cnt",  64'(drop_cnt),  64'(STAT));
        check("ovf_frame_cnt", 64'(frame_cnt), 64'(4 * STAT));
        out_ready = 1'b1;
        wait_beats(base + 128, 400);
        verify_frame(base, 32'hC000_0100);
        verify_frame(base + 64, 32'hC000_0200);
        pulse_clr();
        check("ovf_cleared", 64'(ovf), 64'd0);

        // Skipped index drops the frame; next clean frame is intact.
        base = beat_cnt;
        for (int i = 0; i < 10; i++) send(6'(i), 32'hD000_0000 + 32'(i), 1'b0);
        send(6'd11, 32'hD000_000B, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("skip_seq_err",   64'(seq_err),   64'd1);
        check("skip_drop_cnt",  64'(drop_cnt),  64'(2 * STAT));
        check("skip_no_beats",  64'(beat_cnt - base), 64'd0);
        check("skip_out_valid", 64'(out_valid), 64'd0);
        send_frame(32'hD000_0000);
        wait_beats(base + 64, 200);
        verify_frame(base, 32'hD000_0000);
        check("skip_frame_cnt", 64'(frame_cnt), 64'(5 * STAT));

        // Clear versus simultaneous error: the error wins.
        pulse_clr();
        check("clr_seq_err", 64'(seq_err), 64'd0);
        in_valid = 1'b1; in_freq = 6'd5; err_clr = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; err_clr = 1'b0;
        check("clr_vs_err", 64'(seq_err), 64'd1);
        pulse_clr();
        check("clr_again", 64'(seq_err), 64'd0);

        // Restart mid-frame: only the second frame comes out.
        base = beat_cnt;
        for (int i = 0; i <= 20; i++) send(6'(i), 32'hE000_0000 + 32'(i), 1'b0);
        send_frame(32'hF000_0000);
        wait_beats(base + 64, 300);
        repeat (10) @(posedge clk);
        #1;
        check("restart_count",     64'(beat_cnt - base), 64'd64);
        verify_frame(base, 32'hF000_0000);
        check("restart_seq_err",   64'(seq_err),   64'd1);
        check("restart_drop_cnt",  64'(drop_cnt),  64'(3 * STAT));
        check("restart_frame_cnt", 64'(frame_cnt), 64'(6 * STAT));

        // Asynchronous reset in the middle of replay.
        base = beat_cnt;
        send_frame(32'h6000_0000);
        wait_beats(base + 30, 200);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_seq_err",   64'(seq_err),   64'd0);
        check("mid_rst_ovf",       64'(ovf),       64'd0);
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("mid_rst_drop_cnt",  64'(drop_cnt),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        base = beat_cnt;
        send_frame(32'h7000_0000);
        wait_beats(base + 64, 200);
        verify_frame(base, 32'h7000_0000);
        check("post_rst_frame_cnt", 64'(frame_cnt), 64'(STAT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
